// File: rtl/seg_scan_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_tx_pkg                                                      |
// | Shared constants and hex-to-segment encoding for the digit scanner.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg_scan_tx_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEL_NONE   = 8'hFF;

  // Active-low g..a patterns, entry 15 first down to entry 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [7:0] seg7_code(input logic [3:0] nib, input logic dp);
    return {~dp, HEX_SEG[nib]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_tx_hex_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_to_seg7                                                          |
// | Combinational nibble + decimal point to active-low 8-bit code.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hex_to_seg7
  import seg_scan_tx_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg7_code(nibble_i, dp_i);

endmodule
`default_nettype wire

// File: rtl/seg_scan_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_tx                                                          |
// | Double-buffered 8-digit multiplexed seven-segment scanner.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_scan_tx
  import seg_scan_tx_pkg::*;
#(
  parameter int CLK_DIV  = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data_i,
  input  logic [7:0]  disp_dp_i,
  input  logic        disp_load_i,
  input  logic        disp_en_i,
  output logic [7:0]  o_seg_o,
  output logic [7:0]  o_sel_o,
  output logic        frame_done_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      act_data_q, act_data_d;
  logic [7:0]       act_dp_q, act_dp_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       sel_q, sel_d;

  logic             slot_end;
  logic             frame_end;
  logic [7:0]       blank_mask;
  logic             zero_above;
  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic [7:0]       cur_seg;

  assign cur_nib = act_data_q[{idx_q, 2'b00} +: 4];
  assign cur_dp  = act_dp_q[idx_q];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (cur_nib),
    .dp_i     (cur_dp),
    .seg_o    (cur_seg)
  );

  // Digit i blanks when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above    = zero_above & (act_data_q[4*i +: 4] == 4'h0);
      blank_mask[i] = BLANK_LZ & zero_above;
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    seg_d        = SEG_BLANK;
    sel_d        = SEL_NONE;
    slot_end     = (cnt_q == CNT_LAST);
    frame_end    = disp_en_i & slot_end & (idx_q == IDX_LAST);

    if (disp_en_i) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sel_d = ~(8'b1 << idx_q);
      seg_d = blank_mask[idx_q] ? {~cur_dp, 7'h7F} : cur_seg;
    end else begin
      cnt_d = '0;
      idx_d = '0;
    end

    if (frame_end && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end

    // With the scan stopped nothing can tear, so a load goes straight live.
    if (disp_load_i) begin
      pend_data_d = disp_data_i;
      pend_dp_d   = disp_dp_i;
      if (disp_en_i) begin
        pend_valid_d = 1'b1;
      end else begin
        act_data_d   = disp_data_i;
        act_dp_d     = disp_dp_i;
        pend_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      sel_q        <= SEL_NONE;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
    end
  end

  assign o_seg_o      = seg_q;
  assign o_sel_o      = sel_q;
  assign frame_done_o = frame_end & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_tx                                                       |
// | Directed bench for seg_scan_tx, blanking and non-blanking builds.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seg_scan_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] disp_data_i;
  logic [7:0]  disp_dp_i;
  logic        disp_load_i;
  logic        disp_en_i;
  logic [7:0]  seg_a, sel_a, seg_b, sel_b;
  logic        fd_a, fd_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_tx #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut_lz (
    .clk          (clk),
    .rst          (rst),
    .disp_data_i  (disp_data_i),
    .disp_dp_i    (disp_dp_i),
    .disp_load_i  (disp_load_i),
    .disp_en_i    (disp_en_i),
    .o_seg_o      (seg_a),
    .o_sel_o      (sel_a),
    .frame_done_o (fd_a)
  );

  seg_scan_tx #(.CLK_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk          (clk),
    .rst          (rst),
    .disp_data_i  (disp_data_i),
    .disp_dp_i    (disp_dp_i),
    .disp_load_i  (disp_load_i),
    .disp_en_i    (disp_en_i),
    .o_seg_o      (seg_b),
    .o_sel_o      (sel_b),
    .frame_done_o (fd_b)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] dp);
    disp_data_i = v;
    disp_dp_i   = dp;
    disp_load_i = 1'b1;
    step();
    disp_load_i = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (fd_a !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (fd_a !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: frame_done_o got %b after %0d cycles, expected 1", fd_a, n);
    end
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (sel_a !== 8'hFF || seg_a !== 8'hFF || fd_a !== 1'b0) begin
      errors++;
      $display("FAIL %s lz: sel=%h seg=%h fd=%b, expected FF FF 0", name, sel_a, seg_a, fd_a);
    end
    checks++;
    if (sel_b !== 8'hFF || seg_b !== 8'hFF || fd_b !== 1'b0) begin
      errors++;
      $display("FAIL %s nb: sel=%h seg=%h fd=%b, expected FF FF 0", name, sel_b, seg_b, fd_b);
    end
  endtask

  // Called one cycle after a frame boundary; walks the next full frame.
  task automatic check_digits(input string name, input logic [7:0][7:0] exp_a,
                              input logic [7:0][7:0] exp_b);
    logic [7:0] exp_sel;
    for (int d = 0; d < 8; d++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        exp_sel = ~(8'h01 << d);
        if (k == 0) begin
          checks++;
          if (sel_a !== exp_sel || sel_b !== exp_sel) begin
            errors++;
            $display("FAIL %s digit%0d sel: got %h/%h expected %h", name, d, sel_a, sel_b, exp_sel);
          end
          checks++;
          if (seg_a !== exp_a[d]) begin
            errors++;
            $display("FAIL %s digit%0d seg_lz: got %h expected %h", name, d, seg_a, exp_a[d]);
          end
          checks++;
          if (seg_b !== exp_b[d]) begin
            errors++;
            $display("FAIL %s digit%0d seg_nb: got %h expected %h", name, d, seg_b, exp_b[d]);
          end
        end
        if (d == 7 && k == 2) begin
          checks++;
          if (fd_a !== 1'b1 || fd_b !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_done: got %b/%b expected 1", name, fd_a, fd_b);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_en_i = 1'b0; disp_load_i = 1'b0;
    disp_data_i = '0; disp_dp_i = '0;
    repeat (3) step();
    check_dark("reset_hold");
    rst = 1'b0;
    disp_en_i = 1'b1;
    check_dark("reset_release");
    check_digits("reset_frame", {{7{8'hFF}}, 8'hC0}, {8{8'hC0}});
  endtask

  task automatic test_load_small();
    load(32'h0000_001E, 8'h00);
    wait_frame();
    step();
    check_digits("load_1e", {{6{8'hFF}}, 8'hF9, 8'h86}, {{6{8'hC0}}, 8'hF9, 8'h86});
  endtask

  task automatic test_mid_frame_load();
    repeat (8) step();
    load(32'h89AB_CDEF, 8'h00);
    repeat (3) step();
    checks++;
    if (sel_a !== 8'hFB || seg_a !== 8'hFF || seg_b !== 8'hC0) begin
      errors++;
      $display("FAIL mid_frame_tear: sel=%h seg_lz=%h seg_nb=%h expected FB FF C0", sel_a, seg_a, seg_b);
    end
    wait_frame();
    step();
    check_digits("load_89ab",
                 {8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E},
                 {8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E});
  endtask

  task automatic test_back_to_back();
    load(32'h1234_5678, 8'h00);
    repeat (2) step();
    load(32'h0000_0030, 8'h00);
    wait_frame();
    load(32'h0000_0456, 8'h00);
    check_digits("two_loads", {{6{8'hFF}}, 8'hB0, 8'hC0}, {{6{8'hC0}}, 8'hB0, 8'hC0});
    check_digits("boundary_load", {{5{8'hFF}}, 8'h99, 8'h92, 8'h82},
                 {{5{8'hC0}}, 8'h99, 8'h92, 8'h82});
  endtask

  task automatic test_dp();
    load(32'h0000_0000, 8'h01);
    wait_frame();
    step();
    check_digits("dp0", {{7{8'hFF}}, 8'h40}, {{7{8'hC0}}, 8'h40});
  endtask

  task automatic test_disable();
    repeat (14) step();
    checks++;
    if (sel_a !== 8'hF7) begin
      errors++;
      $display("FAIL disable_pre: sel got %h expected F7", sel_a);
    end
    disp_en_i = 1'b0;
    step();
    check_dark("disable_next");
    load(32'h0000_0021, 8'h00);
    step();
    check_dark("disable_hold");
    disp_en_i = 1'b1;
    check_dark("reenable_edge");
    step();
    checks++;
    if (sel_a !== 8'hFE || seg_a !== 8'hF9 || seg_b !== 8'hF9) begin
      errors++;
      $display("FAIL reenable_d0: sel=%h seg_lz=%h seg_nb=%h expected FE F9 F9", sel_a, seg_a, seg_b);
    end
    repeat (3) step();
    checks++;
    if (sel_a !== 8'hFE) begin
      errors++;
      $display("FAIL reenable_slot_end: sel got %h expected FE", sel_a);
    end
    step();
    checks++;
    if (sel_a !== 8'hFD || seg_a !== 8'hA4 || seg_b !== 8'hA4) begin
      errors++;
      $display("FAIL reenable_d1: sel=%h seg_lz=%h seg_nb=%h expected FD A4 A4", sel_a, seg_a, seg_b);
    end
  endtask

  task automatic test_reset_mid_scan();
    rst = 1'b1;
    step();
    check_dark("rst_mid_scan");
    repeat (2) step();
    rst = 1'b0;
    check_dark("rst_mid_release");
    step();
    checks++;
    if (sel_a !== 8'hFE || seg_a !== 8'hC0 || seg_b !== 8'hC0) begin
      errors++;
      $display("FAIL rst_d0: sel=%h seg_lz=%h seg_nb=%h expected FE C0 C0", sel_a, seg_a, seg_b);
    end
    repeat (4) step();
    checks++;
    if (sel_a !== 8'hFD || seg_a !== 8'hFF || seg_b !== 8'hC0) begin
      errors++;
      $display("FAIL rst_d1: sel=%h seg_lz=%h seg_nb=%h expected FD FF C0", sel_a, seg_a, seg_b);
    end
  endtask

  initial begin
    test_reset();
    test_load_small();
    test_mid_frame_load();
    test_back_to_back();
    test_dp();
    test_disable();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_tx.md
Name: seg_scan_tx

Overview:
- Transmit end of the board display interface: drives the time-multiplexed 8-digit seven-segment bus (`o_seg_o`/`o_sel_o`) that the top level exposes.
- The CPU core or debug logic loads a 32-bit value, shown as 8 hex digits; the block scans one digit at a time at a divided rate.
- New values are double-buffered so a frame never shows a mix of old and new digits.
- Sits between the core result path (e.g. egg-drop answer register) and the top-level pins.

Parameters:
- CLK_DIV, 100000, clk cycles each digit stays lit (1 kHz/digit at 100 MHz); legal range 2..2^20.
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all 8 digits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- disp_data_i  in  32  value to display; nibble i goes to digit i
- disp_dp_i  in  8  decimal-point mask; bit i lights the DP of digit i
- disp_load_i  in  1  one-cycle strobe; captures disp_data_i/disp_dp_i into the pending buffer
- disp_en_i  in  1  1 = scan active; 0 = display dark
- o_seg_o  out  8  segments, active-low; [7]=dp, [6:0]=g..a
- o_sel_o  out  8  digit anodes, active-low, one-hot-low when active
- frame_done_o  out  1  one-cycle pulse when digit 7's slot ends

Behaviour:
- Reset state:
  - o_seg_o=8'hFF, o_sel_o=8'hFF, frame_done_o=0.
  - Divider count=0, digit index=0.
  - Active and pending buffers=0; pending-valid=0.
  - Reset mid-scan aborts immediately; the next cycle is dark.
- Divider:
  - cnt increments each cycle while disp_en_i=1.
  - At cnt==CLK_DIV-1: cnt->0 and digit index advances (7 wraps to 0).
- Frame boundary (the cycle digit 7 wraps to 0):
  - frame_done_o=1 for that cycle.
  - If pending-valid=1, pending copies into the active buffer and pending-valid clears.
- Load handling:
  - disp_load_i=1 writes the pending buffer and sets pending-valid; the last load before a boundary wins.
  - A load on the boundary cycle itself lands in pending and is not applied until the next boundary.
  - A load while disp_en_i=0 copies straight to active, since there is no frame to tear.
- Output timing:
  - o_sel_o/o_seg_o are registered and reflect the new digit index 1 cycle after the advance (latency 1).
  - o_sel_o = ~(8'b1 << idx).
- Segment encoding (active-low, dp bit off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
  - DP: o_seg_o[7] = ~dp[idx].
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i (i>0) is blank when active nibbles i..7 are all zero.
  - A blank digit outputs {~dp[i],7'h7F}; its anode is still driven.
- Disable:
  - disp_en_i=0: next cycle o_sel_o=FF, o_seg_o=FF; cnt and idx clear to 0; no frame_done_o.
  - On re-enable, scanning restarts at digit 0 with a full slot.
- Duty and frame length: each digit is lit for exactly CLK_DIV cycles; frame = 8*CLK_DIV cycles.

Decomposition:
- Shared package holds:
  - SEG_BLANK=8'hFF, SEL_NONE=8'hFF
  - the 16-entry hex segment constant table
  - NUM_DIGITS=8
- One sub-module, hex_to_seg7: combinational nibble + dp -> active-low 8-bit code. The scan FSM, divider and buffers stay in seg_scan_tx.

Test Plan (CLK_DIV=4 unless noted):
- Reset, then en=1 with no load:
  - The cycle after reset shows o_sel_o=FF, o_seg_o=FF.
  - With BLANK_LZ=1, digit 0 shows C0 and digits 1..7 show 7F-blank (FF with dp off).
  - frame_done_o pulses every 32 cycles.
- Load 32'h0000_001E, dp=0, then wait one full frame:
  - digit0 o_sel=FE o_seg=86; digit1 o_sel=FD o_seg=F9; digits 2..7 o_seg=FF.
- Load 32'h89AB_CDEF mid-frame:
  - Current frame keeps the old digits.
  - After the next frame_done_o, digits 0..7 show 8E,86,A1,C6,83,88,90,80.
- Two loads in one frame (12345678 then 00000030), plus a load on the exact frame_done cycle:
  - Next frame shows only 00000030 (digit1=B0, digit0=C0).
  - The boundary-cycle load appears one frame later.
- dp=8'h01 with value 0, then BLANK_LZ=0 build:
  - dp=8'h01 gives digit0 o_seg=40.
  - BLANK_LZ=0 build shows C0 on all 8 digits.
- en dropped mid-digit-3, then re-enabled; rst asserted mid-scan:
  - Outputs go FF the next cycle.
  - Re-enable resumes at digit0 with a 4-cycle slot.
  - rst restores all reset values and clears both buffers.
